sram_fifo_ctrl: RTL and testbench

- Single-clock FIFO controller that uses one 38x96 1W1R SRAM macro (write port 0, read port 1, 32-bit write-mask granules) as FIFO storage.
- Sequences the macro's write and read ports from valid/ready push and pop interfaces.
- Hides the macro's one-cycle read latency behind a 2-entry output prefetch buffer, so pop runs at one word per cycle.
- Sits between a streaming producer and consumer. Both macro clocks are tied to this block's clock at the parent level.

---
 rtl/sram_fifo_ctrl_if.sv | 29 ++
 rtl/sram_fifo_ctrl.sv | 114 +++++++++++
 tb/tb_sram_fifo_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_fifo_ctrl_if.sv
// Push/pop streaming interface of the SRAM-backed FIFO controller.
//   flush       : synchronous clear request from the producer/consumer side
//   push_*      : valid/ready write stream into the FIFO
//   pop_*       : valid/ready read stream out of the FIFO
//   count       : total words held by the FIFO
// master: the side that drives stimulus (producer/consumer); slave: the controller.
interface sram_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 96,
  parameter int unsigned CNT_WIDTH  = 6
);
  logic                  flush;
  logic                  push_valid;
  logic                  push_ready;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop_valid;
  logic                  pop_ready;
  logic [DATA_WIDTH-1:0] pop_data;
  logic [CNT_WIDTH-1:0]  count;

  modport master (
    output flush, push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data, count
  );

  modport slave (
    input  flush, push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data, count
  );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller storing words in a 1W1R SRAM macro (write port 0, read port 1).
// The macro's one-cycle read latency is hidden by a 2-entry prefetch buffer
// (head + skid), so the pop side sustains one word per cycle.
//   clk, rst     : sole clock (also clocks the macro), async active-high reset
//   bus          : push/pop streams, flush and occupancy count (slave side)
//   sram_*0      : macro write port controls, combinational from the push handshake
//   sram_*1      : macro read port controls, combinational from the read-issue decision
//   sram_dout1   : macro read data, valid at the edge after the edge that sampled the read
module sram_fifo_ctrl #(
  parameter int unsigned DEPTH      = 38,
  parameter int unsigned DATA_WIDTH = 96,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned NUM_WMASKS = 3,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_fifo_ctrl_if.slave       bus,
  output logic                  sram_csb0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  DepthCnt = CNT_WIDTH'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_WIDTH-1:0]  sram_cnt_q;
  logic                  rd_inflight_q;
  logic [1:0]            buf_cnt_q;
  logic [DATA_WIDTH-1:0] head_q, skid_q;

  logic       push_ready;
  logic       push_fire;
  logic       pop_valid;
  logic       pop_fire;
  logic       issue;
  logic       rd_ret;
  logic [2:0] occ;
  logic [1:0] buf_after_pop;

  // sram_cnt only counts words whose write has already been sampled, so a read can
  // never target the address being written at the same edge.
  assign push_ready = !rst && (sram_cnt_q < DepthCnt);
  assign push_fire  = bus.push_valid && push_ready && !bus.flush;
  assign pop_valid  = (buf_cnt_q != 2'd0);
  assign pop_fire   = pop_valid && bus.pop_ready;

  // Buffer slots already committed after this edge's pop; never underflows since a pop
  // implies buf_cnt >= 1.
  assign occ   = {1'b0, buf_cnt_q} + {2'b00, rd_inflight_q} - {2'b00, pop_fire};
  assign issue = !rst && !bus.flush && (sram_cnt_q != '0) && (occ < 3'd2);

  // An in-flight result arriving during flush is dropped.
  assign rd_ret        = rd_inflight_q && !bus.flush;
  assign buf_after_pop = buf_cnt_q - {1'b0, pop_fire};

  assign sram_csb0   = !push_fire;
  assign sram_wmask0 = push_fire ? '1 : '0;
  assign sram_addr0  = push_fire ? wr_ptr_q : '0;
  assign sram_din0   = push_fire ? bus.push_data : '0;
  assign sram_csb1   = !issue;
  assign sram_addr1  = issue ? rd_ptr_q : '0;

  assign bus.push_ready = push_ready;
  assign bus.pop_valid  = pop_valid;
  assign bus.pop_data   = head_q;
  assign bus.count      = sram_cnt_q + CNT_WIDTH'(rd_inflight_q) + CNT_WIDTH'(buf_cnt_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      sram_cnt_q    <= '0;
      rd_inflight_q <= 1'b0;
      buf_cnt_q     <= 2'd0;
      head_q        <= '0;
      skid_q        <= '0;
    end else if (bus.flush) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      sram_cnt_q    <= '0;
      rd_inflight_q <= 1'b0;
      buf_cnt_q     <= 2'd0;
    end else begin
      if (push_fire) begin
        wr_ptr_q <= (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (issue) begin
        rd_ptr_q <= (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + 1'b1;
      end
      sram_cnt_q    <= sram_cnt_q + CNT_WIDTH'(push_fire) - CNT_WIDTH'(issue);
      rd_inflight_q <= issue;

      // Skid advances to head on pop; returning data fills the first free slot.
      if (pop_fire && (buf_cnt_q == 2'd2)) begin
        head_q <= skid_q;
      end
      if (rd_ret) begin
        if (buf_after_pop == 2'd0) begin
          head_q <= sram_dout1;
        end else begin
          skid_q <= sram_dout1;
        end
      end
      buf_cnt_q <= buf_after_pop + {1'b0, rd_ret};
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed testbench for sram_fifo_ctrl with a behavioural 1W1R SRAM model.
module tb_sram_fifo_ctrl;

  localparam int unsigned DW = 96;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sram_csb0;
  logic [2:0]    sram_wmask0;
  logic [5:0]    sram_addr0;
  logic [DW-1:0] sram_din0;
  logic          sram_csb1;
  logic [5:0]    sram_addr1;
  logic [DW-1:0] sram_dout1 = '0;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  sram_fifo_ctrl_if #(.DATA_WIDTH(96), .CNT_WIDTH(6)) bus ();

  sram_fifo_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .sram_csb0   (sram_csb0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_csb1   (sram_csb1),
    .sram_addr1  (sram_addr1),
    .sram_dout1  (sram_dout1)
  );

  // SRAM macro model: masked write, registered read data.
  logic [DW-1:0] mem [0:63];
  always @(posedge clk) begin
    if (!sram_csb0) begin
      for (int g = 0; g < 3; g++) begin
        if (sram_wmask0[g]) mem[sram_addr0][g*32 +: 32] <= sram_din0[g*32 +: 32];
      end
    end
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  // Port activity monitor.
  int         wr_wraps = 0, rd_wraps = 0, rd_issues = 0, collisions = 0;
  logic [5:0] last_waddr = '0, last_raddr = '0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      last_waddr <= '0;
      last_raddr <= '0;
    end else begin
      if (!sram_csb0) begin
        if (last_waddr == 6'd37 && sram_addr0 == 6'd0) wr_wraps <= wr_wraps + 1;
        last_waddr <= sram_addr0;
      end
      if (!sram_csb1) begin
        rd_issues <= rd_issues + 1;
        if (last_raddr == 6'd37 && sram_addr1 == 6'd0) rd_wraps <= rd_wraps + 1;
        last_raddr <= sram_addr1;
      end
      if (!sram_csb0 && !sram_csb1 && sram_addr0 == sram_addr1) collisions <= collisions + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.flush      = 1'b0;
    bus.push_valid = 1'b0;
    bus.push_data  = '0;
    bus.pop_ready  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Waits up to 20 cycles for pop_valid.
  task automatic wait_pop_valid(input string name);
    int cyc = 0;
    while (bus.pop_valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    compared++;
    if (bus.pop_valid !== 1'b1) begin
      mismatched++; $display("FAIL %s_timeout: pop_valid=%b want 1", name, bus.pop_valid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    bus.push_valid = 1'b1;
    bus.push_data  = 96'h55;
    rst = 1'b1;
    #1;
    compared++; if (bus.pop_valid !== 1'b0) begin
      mismatched++; $display("FAIL reset_pop_valid: got %b want 0", bus.pop_valid); end
    compared++; if (bus.count !== 6'd0) begin
      mismatched++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    compared++; if (bus.push_ready !== 1'b0) begin
      mismatched++; $display("FAIL reset_push_ready: got %b want 0", bus.push_ready); end
    compared++; if (sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1) begin
      mismatched++; $display("FAIL reset_csb: got %b%b want 11", sram_csb0, sram_csb1); end
    compared++; if (sram_addr0 !== 6'd0 || sram_addr1 !== 6'd0) begin
      mismatched++; $display("FAIL reset_addr: got %0d/%0d want 0/0", sram_addr0, sram_addr1); end
    tick();
    compared++; if (sram_csb0 !== 1'b1) begin
      mismatched++; $display("FAIL reset_held_csb0: got %b want 1", sram_csb0); end
    idle();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    bus.push_valid = 1'b1;
    bus.push_data  = 96'h1;
    #1;
    compared++; if (sram_csb0 !== 1'b0 || sram_addr0 !== 6'd0) begin
      mismatched++; $display("FAIL single_write: csb0=%b addr0=%0d want 0/0", sram_csb0, sram_addr0); end
    compared++; if (sram_wmask0 !== 3'b111 || sram_din0 !== 96'h1) begin
      mismatched++; $display("FAIL single_wdata: mask=%b din=%0h want 111/1", sram_wmask0, sram_din0); end
    compared++; if (sram_csb1 !== 1'b1) begin
      mismatched++; $display("FAIL single_no_early_read: csb1=%b want 1", sram_csb1); end
    tick();
    bus.push_valid = 1'b0;
    #1;
    compared++; if (sram_csb1 !== 1'b0 || sram_addr1 !== 6'd0) begin
      mismatched++; $display("FAIL single_read: csb1=%b addr1=%0d want 0/0", sram_csb1, sram_addr1); end
    tick();
    compared++; if (bus.pop_valid !== 1'b0) begin
      mismatched++; $display("FAIL single_latency_early: pop_valid=%b want 0", bus.pop_valid); end
    tick();
    compared++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 96'h1) begin
      mismatched++; $display("FAIL single_pop: valid=%b data=%0h want 1/1", bus.pop_valid, bus.pop_data); end
    compared++; if (bus.count !== 6'd1) begin
      mismatched++; $display("FAIL single_count: got %0d want 1", bus.count); end
    bus.pop_ready = 1'b1;
    tick();
    bus.pop_ready = 1'b0;
    compared++; if (bus.count !== 6'd0 || bus.pop_valid !== 1'b0) begin
      mismatched++; $display("FAIL single_drained: count=%0d valid=%b want 0/0", bus.count, bus.pop_valid); end
  endtask

  task automatic test_fill();
    int i = 0, j = 0, cyc = 0, r0;
    logic acc;
    do_reset();
    r0 = rd_issues;
    while (i < 40 && cyc < 200) begin
      bus.push_valid = 1'b1;
      bus.push_data  = 96'(i);
      acc = bus.push_ready;
      tick();
      if (acc) i++;
      cyc++;
    end
    bus.push_valid = 1'b0;
    compared++; if (i != 40) begin
      mismatched++; $display("FAIL fill_accepts: got %0d want 40", i); end
    compared++; if (bus.push_ready !== 1'b0) begin
      mismatched++; $display("FAIL fill_push_ready: got %b want 0", bus.push_ready); end
    compared++; if (bus.count !== 6'd40) begin
      mismatched++; $display("FAIL fill_count: got %0d want 40", bus.count); end
    compared++; if (rd_issues - r0 != 2) begin
      mismatched++; $display("FAIL fill_buffered: got %0d reads want 2", rd_issues - r0); end
    bus.push_valid = 1'b1;
    bus.push_data  = 96'hBAD;
    #1;
    compared++; if (sram_csb0 !== 1'b1) begin
      mismatched++; $display("FAIL fill_push_ignored: csb0=%b want 1", sram_csb0); end
    tick();
    bus.push_valid = 1'b0;
    bus.pop_ready  = 1'b1;
    cyc = 0;
    while (j < 40 && cyc < 400) begin
      if (bus.pop_valid === 1'b1) begin
        compared++; if (bus.pop_data !== 96'(j)) begin
          mismatched++; $display("FAIL fill_order: got %0h want %0h", bus.pop_data, j); end
        j++;
      end
      tick();
      cyc++;
    end
    bus.pop_ready = 1'b0;
    compared++; if (j != 40 || bus.count !== 6'd0) begin
      mismatched++; $display("FAIL fill_drain: popped %0d count %0d want 40/0", j, bus.count); end
  endtask

  task automatic test_stream();
    int pushed = 0, popped = 0, bubbles = 0, bad = 0, cyc = 0;
    int w0, r0, c0;
    logic started = 1'b0, pf, popf;
    do_reset();
    w0 = wr_wraps; r0 = rd_wraps; c0 = collisions;
    bus.pop_ready = 1'b1;
    while (popped < 200 && cyc < 1000) begin
      bus.push_valid = (pushed < 200);
      bus.push_data  = 96'(pushed);
      pf   = bus.push_valid && bus.push_ready;
      popf = bus.pop_valid;
      if (started && !popf) bubbles++;
      if (popf) begin
        started = 1'b1;
        if (bus.pop_data !== 96'(popped)) bad++;
      end
      tick();
      if (pf) pushed++;
      if (popf) popped++;
      cyc++;
    end
    idle();
    compared++; if (popped != 200) begin
      mismatched++; $display("FAIL stream_popped: got %0d want 200", popped); end
    compared++; if (bubbles != 0) begin
      mismatched++; $display("FAIL stream_bubbles: got %0d want 0", bubbles); end
    compared++; if (bad != 0) begin
      mismatched++; $display("FAIL stream_data: %0d bad words want 0", bad); end
    compared++; if (wr_wraps - w0 < 5 || rd_wraps - r0 < 5) begin
      mismatched++; $display("FAIL stream_wraps: wr %0d rd %0d want >=5", wr_wraps - w0, rd_wraps - r0); end
    compared++; if (collisions != c0) begin
      mismatched++; $display("FAIL stream_collision: got %0d want 0", collisions - c0); end
  endtask

  task automatic test_overlap();
    int c0;
    do_reset();
    c0 = collisions;
    bus.push_valid = 1'b1;
    bus.push_data  = 96'hAAA;
    tick();
    bus.push_valid = 1'b0;
    wait_pop_valid("overlap_first");
    bus.push_valid = 1'b1;
    bus.push_data  = 96'hBBB;
    bus.pop_ready  = 1'b1;
    #1;
    compared++; if (bus.pop_data !== 96'hAAA) begin
      mismatched++; $display("FAIL overlap_first: got %0h want aaa", bus.pop_data); end
    compared++; if (sram_csb1 !== 1'b1 || sram_csb0 !== 1'b0) begin
      mismatched++; $display("FAIL overlap_ports: csb0=%b csb1=%b want 0/1", sram_csb0, sram_csb1); end
    tick();
    idle();
    wait_pop_valid("overlap_second");
    compared++; if (bus.pop_data !== 96'hBBB) begin
      mismatched++; $display("FAIL overlap_second: got %0h want bbb", bus.pop_data); end
    bus.pop_ready = 1'b1;
    tick();
    bus.pop_ready = 1'b0;
    compared++; if (bus.count !== 6'd0 || collisions != c0) begin
      mismatched++; $display("FAIL overlap_end: count=%0d coll=%0d want 0/0", bus.count, collisions - c0); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.push_valid = 1'b1;
      bus.push_data  = 96'(100 + i);
      tick();
    end
    bus.push_valid = 1'b0;
    tick();
    tick();
    compared++; if (bus.count !== 6'd10) begin
      mismatched++; $display("FAIL flush_pre_count: got %0d want 10", bus.count); end
    bus.pop_ready = 1'b1;
    #1;
    compared++; if (sram_csb1 !== 1'b0) begin
      mismatched++; $display("FAIL flush_pre_issue: csb1=%b want 0", sram_csb1); end
    tick();
    bus.pop_ready  = 1'b0;
    bus.flush      = 1'b1;
    bus.push_valid = 1'b1;
    bus.push_data  = 96'hDEAD;
    #1;
    compared++; if (bus.count !== 6'd9) begin
      mismatched++; $display("FAIL flush_inflight_count: got %0d want 9", bus.count); end
    compared++; if (sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1) begin
      mismatched++; $display("FAIL flush_csb: got %b%b want 11", sram_csb0, sram_csb1); end
    tick();
    idle();
    compared++; if (bus.count !== 6'd0 || bus.pop_valid !== 1'b0) begin
      mismatched++; $display("FAIL flush_clear: count=%0d valid=%b want 0/0", bus.count, bus.pop_valid); end
    tick();
    compared++; if (bus.count !== 6'd0 || bus.pop_valid !== 1'b0) begin
      mismatched++; $display("FAIL flush_late_data: count=%0d valid=%b want 0/0", bus.count, bus.pop_valid); end
    bus.push_valid = 1'b1;
    bus.push_data  = 96'hA5;
    #1;
    compared++; if (sram_csb0 !== 1'b0 || sram_addr0 !== 6'd0) begin
      mismatched++; $display("FAIL flush_restart_addr: csb0=%b addr0=%0d want 0/0", sram_csb0, sram_addr0); end
    tick();
    bus.push_valid = 1'b0;
    wait_pop_valid("flush_restart");
    compared++; if (bus.pop_data !== 96'hA5 || bus.count !== 6'd1) begin
      mismatched++; $display("FAIL flush_restart_data: data=%0h count=%0d want a5/1", bus.pop_data, bus.count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      bus.push_valid = 1'b1;
      bus.push_data  = 96'(i + 500);
      bus.pop_ready  = 1'b1;
      tick();
    end
    compared++; if (bus.pop_valid !== 1'b1) begin
      mismatched++; $display("FAIL arst_precondition: pop_valid=%b want 1", bus.pop_valid); end
    #2;
    rst = 1'b1;
    #1;
    compared++; if (bus.pop_valid !== 1'b0 || bus.count !== 6'd0) begin
      mismatched++; $display("FAIL arst_outputs: valid=%b count=%0d want 0/0", bus.pop_valid, bus.count); end
    compared++; if (sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1 || bus.push_ready !== 1'b0) begin
      mismatched++; $display("FAIL arst_ctrl: csb=%b%b ready=%b want 11/0", sram_csb0, sram_csb1, bus.push_ready); end
    @(negedge clk);
    idle();
    rst = 1'b0;
    tick();
    bus.push_valid = 1'b1;
    bus.push_data  = 96'h77;
    #1;
    compared++; if (sram_csb0 !== 1'b0 || sram_addr0 !== 6'd0) begin
      mismatched++; $display("FAIL arst_restart_addr: csb0=%b addr0=%0d want 0/0", sram_csb0, sram_addr0); end
    tick();
    bus.push_valid = 1'b0;
    wait_pop_valid("arst_restart");
    compared++; if (bus.pop_data !== 96'h77 || bus.count !== 6'd1) begin
      mismatched++; $display("FAIL arst_restart_data: data=%0h count=%0d want 77/1", bus.pop_data, bus.count); end
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_overlap();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
